inst_fetch_queue: RTL and testbench

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

---
 rtl/inst_fetch_queue.sv | 108 ++++++++++
 tb/tb_inst_fetch_queue.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: issues 3-wide bundle fetches to a 1-cycle memory
// and buffers returned bundles in a credit-limited circular queue for decode.
module inst_fetch_queue #(
  parameter int              IW       = 16,
  parameter int              PCW      = 16,
  parameter int              DEPTH    = 4,
  parameter logic [PCW-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [PCW-1:0]    flush_pc,
  input  logic              freeze_front,
  output logic              imem_req,
  output logic [PCW-1:0]    imem_addr,
  input  logic [3*IW-1:0]   imem_rdata,
  output logic [2:0]        valid_pc,
  output logic [IW-1:0]     inst0,
  output logic [IW-1:0]     inst1,
  output logic [IW-1:0]     inst2,
  output logic [PCW-1:0]    pc_out,
  output logic              empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PCW-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PCW-1:0]  req_pc_q, req_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic            inflight_q, inflight_d;

  logic [3*IW-1:0] data_q [DEPTH];
  logic [PCW-1:0]  pc_q   [DEPTH];
  logic [2:0]      mask_q [DEPTH];

  logic            credit;
  logic            enq;
  logic            deq;
  logic            live;
  logic            show;

  // A request is allowed only if a queue slot is free for every outstanding response.
  assign credit    = ({1'b0, count_q} + (CW+1)'(inflight_q)) < (CW+1)'(DEPTH);
  assign live      = rst & ~flush;
  assign imem_req  = live & credit;
  assign imem_addr = fetch_pc_q;
  assign enq       = live & inflight_q;
  assign deq       = live & (count_q != '0) & ~freeze_front;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    inflight_d = inflight_q;
    if (!rst || flush) begin
      fetch_pc_d = rst ? flush_pc : RESET_PC;
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      inflight_d = 1'b0;
    end else begin
      if (imem_req) begin
        fetch_pc_d = fetch_pc_q + PCW'(3);
        req_pc_d   = fetch_pc_q;
      end
      inflight_d = imem_req;
      tail_d     = tail_q + PW'(enq);
      head_d     = head_q + PW'(deq);
      count_d    = count_q + CW'(enq) - CW'(deq);
    end
  end

  always_ff @(posedge clk) begin
    fetch_pc_q <= fetch_pc_d;
    req_pc_q   <= req_pc_d;
    count_q    <= count_d;
    head_q     <= head_d;
    tail_q     <= tail_d;
    inflight_q <= inflight_d;
    if (enq) begin
      assert (!(count_q == CW'(DEPTH) && freeze_front))
        else $error("inst_fetch_queue: enqueue into full queue");
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      data_q[tail_q] <= imem_rdata;
      pc_q[tail_q]   <= req_pc_q;
      mask_q[tail_q] <= 3'b111;
    end
  end

  // Head is hidden during reset and flush cycles so decode never sees a doomed bundle.
  assign show     = live & (count_q != '0);
  assign empty    = ~show;
  assign valid_pc = show ? mask_q[head_q] : 3'b000;
  assign inst0    = show ? data_q[head_q][IW-1:0]      : '0;
  assign inst1    = show ? data_q[head_q][2*IW-1:IW]   : '0;
  assign inst2    = show ? data_q[head_q][3*IW-1:2*IW] : '0;
  assign pc_out   = show ? pc_q[head_q] : '0;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue: memory model returns mem[a]=a one cycle
// after each request; every step checks outputs against hand-derived values.
module tb_inst_fetch_queue;

  localparam int IW = 16;
  localparam int PCW = 16;
  localparam int DEPTH = 4;

  logic            clk;
  logic            rst;
  logic            flush;
  logic [PCW-1:0]  flush_pc;
  logic            freeze_front;
  logic            imem_req;
  logic [PCW-1:0]  imem_addr;
  logic [3*IW-1:0] imem_rdata;
  logic [2:0]      valid_pc;
  logic [IW-1:0]   inst0, inst1, inst2;
  logic [PCW-1:0]  pc_out;
  logic            empty;

  int vectors = 0;
  int miscompares = 0;

  inst_fetch_queue #(.IW(IW), .PCW(PCW), .DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .flush(flush), .flush_pc(flush_pc),
    .freeze_front(freeze_front), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .valid_pc(valid_pc), .inst0(inst0), .inst1(inst1),
    .inst2(inst2), .pc_out(pc_out), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1-cycle memory, mem[a] = a; filler pattern when no request was made.
  logic [15:0] a1, a2;
  assign a1 = imem_addr + 16'd1;
  assign a2 = imem_addr + 16'd2;
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= {a2, a1, imem_addr};
    else          imem_rdata <= {3{16'hDEAD}};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [15:0] pc);
    chk({tag, "_valid"}, 32'(valid_pc), 32'h7);
    chk({tag, "_pc"},    32'(pc_out),   32'(pc));
    chk({tag, "_i0"},    32'(inst0),    32'(pc));
    chk({tag, "_i1"},    32'(inst1),    32'(16'(pc + 16'd1)));
    chk({tag, "_i2"},    32'(inst2),    32'(16'(pc + 16'd2)));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_empty"}, 32'(empty),    32'h1);
    chk({tag, "_valid"}, 32'(valid_pc), 32'h0);
    chk({tag, "_pc"},    32'(pc_out),   32'h0);
    chk({tag, "_i0"},    32'(inst0),    32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] exp_pc;
    rst = 1'b0; flush = 1'b0; flush_pc = '0; freeze_front = 1'b0;

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    chk("rst_req", 32'(imem_req), 32'h0);
    chk_idle("rst");
    chk("rst_i1", 32'(inst1), 32'h0);
    chk("rst_i2", 32'(inst2), 32'h0);

    // Streaming from reset
    @(negedge clk); rst = 1'b1; #1;
    chk("s0_req", 32'(imem_req), 32'h1);
    chk("s0_addr", 32'(imem_addr), 32'h0);
    chk("s0_empty", 32'(empty), 32'h1);
    @(negedge clk); #1;
    chk("s1_addr", 32'(imem_addr), 32'h3);
    chk_idle("s1");
    for (int k = 2; k <= 6; k++) begin
      @(negedge clk); #1;
      chk_head("stream", 16'(3 * (k - 2)));
      chk("stream_req", 32'(imem_req), 32'h1);
      chk("stream_addr", 32'(imem_addr), 32'(3 * k));
    end

    // Backpressure from reset
    @(negedge clk); rst = 1'b0; freeze_front = 1'b1;
    @(negedge clk); rst = 1'b1; #1;
    chk("bp0_req", 32'(imem_req), 32'h1);
    chk("bp0_addr", 32'(imem_addr), 32'h0);
    for (int d = 1; d <= 3; d++) begin
      @(negedge clk); #1;
      chk("bp_req", 32'(imem_req), 32'h1);
      chk("bp_addr", 32'(imem_addr), 32'(3 * d));
    end
    @(negedge clk); #1;
    chk("bp4_req", 32'(imem_req), 32'h0);
    @(negedge clk); #1;
    chk("bp5_req", 32'(imem_req), 32'h0);
    chk_head("bp5", 16'h0);
    @(negedge clk); freeze_front = 1'b0; #1;
    chk("bp6_req", 32'(imem_req), 32'h0);
    chk_head("bp6", 16'h0);
    @(negedge clk); #1;
    chk_head("bp7", 16'h3);
    chk("bp7_req", 32'(imem_req), 32'h1);
    chk("bp7_addr", 32'(imem_addr), 32'hC);
    @(negedge clk); #1; chk_head("bp8", 16'h6);
    @(negedge clk); #1; chk_head("bp9", 16'h9);
    @(negedge clk); #1; chk_head("bp10", 16'hC);

    // Flush while a response arrives
    @(negedge clk); flush = 1'b1; flush_pc = 16'h0040; #1;
    chk("fl0_req", 32'(imem_req), 32'h0);
    chk_idle("fl0");
    @(negedge clk); flush = 1'b0; #1;
    chk("fl1_req", 32'(imem_req), 32'h1);
    chk("fl1_addr", 32'(imem_addr), 32'h40);
    chk_idle("fl1");
    @(negedge clk); #1;
    chk("fl2_addr", 32'(imem_addr), 32'h43);
    chk_idle("fl2");
    @(negedge clk); #1;
    chk_head("fl3", 16'h0040);

    // Alternating freeze with a partly full queue
    @(negedge clk); flush = 1'b1; flush_pc = 16'h0100; freeze_front = 1'b1;
    @(negedge clk); flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    exp_pc = 16'h0100;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); freeze_front = (i % 2 == 0); #1;
      chk("alt_valid", 32'(valid_pc), 32'h7);
      if (!freeze_front) begin
        chk_head("alt", exp_pc);
        exp_pc = exp_pc + 16'd3;
      end
    end
    chk("alt_count", 32'(exp_pc), 32'h10C);

    // PC wrap-around
    @(negedge clk); flush = 1'b1; flush_pc = 16'hFFFE; freeze_front = 1'b0;
    @(negedge clk); flush = 1'b0; #1;
    chk("wr1_addr", 32'(imem_addr), 32'hFFFE);
    @(negedge clk); #1;
    chk("wr2_addr", 32'(imem_addr), 32'h0001);
    @(negedge clk); #1;
    chk_head("wr3", 16'hFFFE);
    @(negedge clk); #1;
    chk_head("wr4", 16'h0001);

    // Mid-run reset with count=3 and a response in flight
    @(negedge clk); flush = 1'b1; flush_pc = 16'h0200; freeze_front = 1'b1;
    @(negedge clk); flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); #1;
    chk("mr_pre_req", 32'(imem_req), 32'h0);
    chk_head("mr_pre", 16'h0200);
    rst = 1'b0; #1;
    chk("mr_rst_req", 32'(imem_req), 32'h0);
    chk_idle("mr_rst");
    @(negedge clk); rst = 1'b1; #1;
    chk("mr1_req", 32'(imem_req), 32'h1);
    chk("mr1_addr", 32'(imem_addr), 32'h0);
    chk_idle("mr1");
    @(negedge clk); #1;
    chk("mr2_addr", 32'(imem_addr), 32'h3);
    chk_idle("mr2");
    @(negedge clk); #1;
    chk_head("mr3", 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
